// File: rtl/seq_shifter_if.sv
// Request/result handshake bundle for seq_shifter.
// The master side issues requests and consumes results; the slave side is the shifter.
interface seq_shifter_if #(
  parameter int WIDTH = 16
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic [SHW-1:0]   in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_op, in_shamt, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_err
  );

  modport slave (
    input  in_valid, in_data, in_op, in_shamt, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_err
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: accepts one request, shifts by at most STEP bit
// positions per cycle, then holds the result until the consumer takes it.
// Optional rotate-right support is built only when SEQ_SHIFTER_ROR_EN is defined.
//
// state | meaning
// IDLE  | ready for a request
// SHIFT | shifting acc, rem positions still to go
// DONE  | result presented, waiting for out_ready
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic         clk,
  input  logic         reset,
  seq_shifter_if.slave bus,
  output logic         busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

`ifdef SEQ_SHIFTER_ROR_EN
  localparam logic ROR_EN = 1'b1;
  localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);
`else
  localparam logic ROR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   rem;
  logic [2:0]       op;
  logic             carry;
  logic             err;

  logic             accept;
  logic             in_supported;
  logic [SHW-1:0]   k;
  logic [WIDTH:0]   lsl_ext;
  logic [WIDTH:0]   rsh_ext;
  logic [WIDTH:0]   asr_ext;
  logic [WIDTH-1:0] shift_data;
  logic             shift_carry;
`ifdef SEQ_SHIFTER_ROR_EN
  logic [SHW:0]     rot_back;
  logic [WIDTH-1:0] ror_data;
`endif

  assign accept       = (state == IDLE) && bus.in_valid;
  assign in_supported = (bus.in_op <= OP_ASR) || (ROR_EN && (bus.in_op == OP_ROR));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: rem reaching zero this cycle is the same as rem <= STEP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if ((bus.in_shamt == '0) || (bus.in_op == OP_PASS) || !in_supported)
            state_nxt = DONE;
          else
            state_nxt = SHIFT;
        end
      end
      SHIFT:   if (rem <= STEP_W) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One shift step of k positions; the extra bit in each *_ext catches the bit shifted out.
  always_comb begin
    k           = (rem < STEP_W) ? rem : STEP_W;
    lsl_ext     = {1'b0, acc} << k;
    rsh_ext     = {acc, 1'b0} >> k;
    asr_ext     = $signed({acc, 1'b0}) >>> k;
`ifdef SEQ_SHIFTER_ROR_EN
    rot_back    = WIDTH_W - {1'b0, k};
    ror_data    = (acc >> k) | (acc << rot_back);
`endif
    shift_data  = acc;
    shift_carry = carry;
    case (op)
      OP_LSL: begin
        shift_data  = lsl_ext[WIDTH-1:0];
        shift_carry = lsl_ext[WIDTH];
      end
      OP_LSR: begin
        shift_data  = rsh_ext[WIDTH:1];
        shift_carry = rsh_ext[0];
      end
      OP_ASR: begin
        shift_data  = asr_ext[WIDTH:1];
        shift_carry = asr_ext[0];
      end
`ifdef SEQ_SHIFTER_ROR_EN
      OP_ROR: begin
        shift_data  = ror_data;
        shift_carry = ror_data[WIDTH-1];
      end
`endif
      default: begin
        shift_data  = acc;
        shift_carry = carry;
      end
    endcase
  end

  // Operand capture on accept, one step per SHIFT cycle, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      rem   <= '0;
      op    <= OP_PASS;
      carry <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      acc   <= bus.in_data;
      rem   <= bus.in_shamt;
      op    <= bus.in_op;
      carry <= 1'b0;
      err   <= !in_supported;
    end else if (state == SHIFT) begin
      acc   <= shift_data;
      carry <= shift_carry;
      rem   <= rem - k;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = acc;
  assign bus.out_carry = carry;
  assign bus.out_err   = err;
  assign busy          = (state != IDLE);
endmodule
